// File: rtl/ddr_ctrl_ahb_snoop.sv
// rtl/ddr_ctrl_ahb_snoop.sv - passive AHB-lite snoop FIFO with masked address pattern counter
module ddr_ctrl_ahb_snoop #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    parameter int CWIDTH = 16
) (
    input  logic                       i_hclk,
    input  logic                       i_hreset,
    input  logic [AWIDTH-1:0]          i_haddr,
    input  logic                       i_hwrite,
    input  logic                       i_hsel,
    input  logic [1:0]                 i_htrans,
    input  logic                       i_hready,
    input  logic [DWIDTH-1:0]          i_hwdata,
    input  logic [DWIDTH-1:0]          i_hrdata,
    input  logic                       i_snoop_en,
    input  logic [1:0]                 i_snoop_mode,
    input  logic                       i_snoop_pop,
    input  logic                       i_snoop_clr,
    input  logic                       i_pat_en,
    input  logic [AWIDTH-1:0]          i_pat_addr,
    input  logic [AWIDTH-1:0]          i_pat_mask,
    output logic [$clog2(DEPTH+1)-1:0] o_sta_count,
    output logic                       o_sta_empty,
    output logic                       o_sta_full,
    output logic                       o_sta_overflow,
    output logic [AWIDTH-1:0]          o_data_addr,
    output logic [DWIDTH-1:0]          o_data_data,
    output logic                       o_data_write,
    output logic                       o_pat_match,
    output logic [CWIDTH-1:0]          o_pat_count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [AWIDTH-1:0] mem_addr_q [DEPTH];
    logic [AWIDTH-1:0] mem_addr_d [DEPTH];
    logic [DWIDTH-1:0] mem_data_q [DEPTH];
    logic [DWIDTH-1:0] mem_data_d [DEPTH];
    logic              mem_wr_q   [DEPTH];
    logic              mem_wr_d   [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              pend_v_q, pend_v_d;
    logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
    logic              pend_wr_q, pend_wr_d;
    logic              pat_match_q, pat_match_d;
    logic [CWIDTH-1:0] pat_cnt_q, pat_cnt_d;

    logic              mode_ok, addr_acc, complete, is_full, is_empty;
    logic              do_pop, do_push, pat_hit;
    logic [DWIDTH-1:0] cap_data;
    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    logic              unused_htrans0;

    assign unused_htrans0 = i_htrans[0];

    // Bus qualification, completion detection and FIFO handshake decisions.
    always_comb begin
        mode_ok  = (i_snoop_mode == 2'b01) ? i_hwrite :
                   (i_snoop_mode == 2'b10) ? ~i_hwrite : 1'b1;
        addr_acc = i_snoop_en & i_hsel & i_htrans[1] & i_hready & mode_ok;
        complete = pend_v_q & i_hready;
        cap_data = pend_wr_q ? i_hwdata : i_hrdata;
        is_full  = (count_q == CNTW'(DEPTH));
        is_empty = (count_q == '0);
        do_pop   = i_snoop_pop & ~is_empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = complete & (~is_full | do_pop);
        pat_hit  = complete & i_pat_en & (((pend_addr_q ^ i_pat_addr) & i_pat_mask) == '0);
    end

    // Next-state for pending transfer, FIFO storage/pointers and status.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wr_d    = mem_wr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_wr_d   = pend_wr_q;
        pat_match_d = pat_match_q;
        pat_cnt_d   = pat_cnt_q;
        if (i_snoop_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            pend_v_d    = 1'b0;
            pat_match_d = 1'b0;
            pat_cnt_d   = '0;
        end else begin
            if (addr_acc) begin
                pend_v_d    = 1'b1;
                pend_addr_d = i_haddr;
                pend_wr_d   = i_hwrite;
            end else if (complete) begin
                pend_v_d = 1'b0;
            end
            if (do_push) begin
                mem_addr_d[wr_ptr_q] = pend_addr_q;
                mem_data_d[wr_ptr_q] = cap_data;
                mem_wr_d[wr_ptr_q]   = pend_wr_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (complete & ~do_push) begin
                ovf_d = 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
            if (pat_hit) begin
                pat_match_d = 1'b1;
                if (pat_cnt_q != '1) begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_wr_q[i]   <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_wr_q   <= 1'b0;
            pat_match_q <= 1'b0;
            pat_cnt_q   <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wr_q    <= mem_wr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_wr_q   <= pend_wr_d;
            pat_match_q <= pat_match_d;
            pat_cnt_q   <= pat_cnt_d;
        end
    end

    // Status and head view straight from registers.
    always_comb begin
        o_sta_count    = count_q;
        o_sta_empty    = is_empty;
        o_sta_full     = is_full;
        o_sta_overflow = ovf_q;
        o_data_addr    = mem_addr_q[rd_ptr_q];
        o_data_data    = mem_data_q[rd_ptr_q];
        o_data_write   = mem_wr_q[rd_ptr_q];
        o_pat_match    = pat_match_q;
        o_pat_count    = pat_cnt_q;
    end
endmodule

// File: tb/tb_ddr_ctrl_ahb_snoop.sv
// tb/tb_ddr_ctrl_ahb_snoop.sv - self-checking bench for ddr_ctrl_ahb_snoop
module tb_ddr_ctrl_ahb_snoop;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr, hwdata, hrdata, pat_addr, pat_mask;
    logic        hwrite, hsel, hready, snoop_en, pop, clr, pat_en;
    logic [1:0]  htrans, mode;

    logic [2:0]  sta_count, sta_count2;
    logic        sta_empty, sta_full, sta_ovf, d_wr, pm;
    logic        sta_empty2, sta_full2, sta_ovf2, d_wr2, pm2;
    logic [31:0] d_addr, d_data, d_addr2, d_data2;
    logic [15:0] pc;
    logic [3:0]  pc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_ctrl_ahb_snoop #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4), .CWIDTH(16)) dut (
        .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel),
        .i_htrans(htrans), .i_hready(hready), .i_hwdata(hwdata), .i_hrdata(hrdata),
        .i_snoop_en(snoop_en), .i_snoop_mode(mode), .i_snoop_pop(pop), .i_snoop_clr(clr),
        .i_pat_en(pat_en), .i_pat_addr(pat_addr), .i_pat_mask(pat_mask),
        .o_sta_count(sta_count), .o_sta_empty(sta_empty), .o_sta_full(sta_full),
        .o_sta_overflow(sta_ovf), .o_data_addr(d_addr), .o_data_data(d_data),
        .o_data_write(d_wr), .o_pat_match(pm), .o_pat_count(pc));

    ddr_ctrl_ahb_snoop #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4), .CWIDTH(4)) dut_sat (
        .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel),
        .i_htrans(htrans), .i_hready(hready), .i_hwdata(hwdata), .i_hrdata(hrdata),
        .i_snoop_en(snoop_en), .i_snoop_mode(mode), .i_snoop_pop(pop), .i_snoop_clr(clr),
        .i_pat_en(pat_en), .i_pat_addr(pat_addr), .i_pat_mask(pat_mask),
        .o_sta_count(sta_count2), .o_sta_empty(sta_empty2), .o_sta_full(sta_full2),
        .o_sta_overflow(sta_ovf2), .o_data_addr(d_addr2), .o_data_data(d_data2),
        .o_data_write(d_wr2), .o_pat_match(pm2), .o_pat_count(pc2));

    // Reference model: a queue of captured transfers plus the one outstanding address phase.
    typedef struct { logic [31:0] a; logic [31:0] d; logic w; } ent_t;
    ent_t        mq[$];
    logic        m_pv, m_pw, m_ovf, m_pm;
    logic [31:0] m_pa;
    int          m_pc;

    task automatic model_step();
        logic  cmp, ok, acc;
        logic [31:0] dat;
        ent_t  t;
        if (rst || clr) begin
            mq.delete(); m_pv = 0; m_ovf = 0; m_pm = 0; m_pc = 0;
        end else begin
            cmp = m_pv && hready;
            dat = m_pw ? hwdata : hrdata;
            ok  = (mode == 2'b01) ? hwrite : (mode == 2'b10) ? !hwrite : 1'b1;
            acc = snoop_en && hsel && htrans[1] && hready && ok;
            if (pop && mq.size() > 0) t = mq.pop_front();
            if (cmp) begin
                if (mq.size() < 4) mq.push_back('{m_pa, dat, m_pw});
                else m_ovf = 1;
                if (pat_en && (((m_pa ^ pat_addr) & pat_mask) == 0)) begin
                    m_pm = 1;
                    if (m_pc < 65535) m_pc++;
                end
            end
            if (acc) begin m_pv = 1; m_pa = haddr; m_pw = hwrite; end
            else if (cmp) m_pv = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        pop = 0;
        clr = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_count"}, 64'(sta_count), 64'(mq.size()));
        chk({tag, "_empty"}, 64'(sta_empty), 64'(mq.size() == 0));
        chk({tag, "_full"}, 64'(sta_full), 64'(mq.size() == 4));
        chk({tag, "_ovf"}, 64'(sta_ovf), 64'(m_ovf));
        chk({tag, "_pm"}, 64'(pm), 64'(m_pm));
        chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
        if (mq.size() > 0) begin
            chk({tag, "_haddr"}, 64'(d_addr), 64'(mq[0].a));
            chk({tag, "_hdata"}, 64'(d_data), 64'(mq[0].d));
            chk({tag, "_hwr"}, 64'(d_wr), 64'(mq[0].w));
        end
    endtask

    task automatic set_bus(input logic s, input logic [1:0] tr, input logic w,
                           input logic [31:0] a, input logic r);
        hsel = s; htrans = tr; hwrite = w; haddr = a; hready = r;
    endtask

    // One isolated transfer: address phase, then data phase with optional pop.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic p);
        set_bus(1, 2'b10, w, a, 1);
        tick();
        set_bus(0, 2'b00, 0, 32'h0, 1);
        if (w) hwdata = d; else hrdata = d;
        pop = p;
        tick();
    endtask

    typedef struct {
        logic sel; logic [1:0] tr; logic wr; logic [31:0] addr; logic rdy;
        logic [31:0] wd; logic [31:0] rd; logic pp;
        logic [2:0] e_cnt; logic e_empty; logic chk_head;
        logic [31:0] e_addr; logic [31:0] e_data; logic e_wr;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{1, 2'b10, 1, 32'h10, 1, 32'h0,        32'h0,        0, 3'd0, 1, 0, 32'h0,  32'h0,        0};
        tbl[1] = '{1, 2'b10, 0, 32'h14, 1, 32'hDEADBEEF, 32'h0,        0, 3'd1, 0, 1, 32'h10, 32'hDEADBEEF, 1};
        tbl[2] = '{0, 2'b00, 0, 32'h0,  1, 32'h0,        32'h12345678, 0, 3'd2, 0, 1, 32'h10, 32'hDEADBEEF, 1};
        tbl[3] = '{0, 2'b00, 0, 32'h0,  1, 32'h0,        32'h0,        1, 3'd1, 0, 1, 32'h14, 32'h12345678, 0};
        tbl[4] = '{0, 2'b00, 0, 32'h0,  1, 32'h0,        32'h0,        1, 3'd0, 1, 0, 32'h0,  32'h0,        0};
        tbl[5] = '{0, 2'b00, 0, 32'h0,  1, 32'h0,        32'h0,        1, 3'd0, 1, 0, 32'h0,  32'h0,        0};

        rst = 1; clr = 0; pop = 0; snoop_en = 1; mode = 2'b00;
        pat_en = 0; pat_addr = 0; pat_mask = 0; hwdata = 0; hrdata = 0;
        set_bus(0, 2'b00, 0, 32'h0, 1);
        tick(); tick();
        chk("rst_count", 64'(sta_count), 0);
        chk("rst_empty", 64'(sta_empty), 1);
        chk("rst_full", 64'(sta_full), 0);
        chk("rst_ovf", 64'(sta_ovf), 0);
        chk("rst_haddr", 64'(d_addr), 0);
        chk("rst_hdata", 64'(d_data), 0);
        chk("rst_hwr", 64'(d_wr), 0);
        chk("rst_pm", 64'(pm), 0);
        chk("rst_pc", 64'(pc), 0);
        rst = 0;

        // Basic write then read, back-to-back, then pops including one on empty.
        for (int i = 0; i < 6; i++) begin
            set_bus(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].addr, tbl[i].rdy);
            hwdata = tbl[i].wd; hrdata = tbl[i].rd; pop = tbl[i].pp;
            tick();
            chk($sformatf("tbl%0d_count", i), 64'(sta_count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_empty", i), 64'(sta_empty), 64'(tbl[i].e_empty));
            if (tbl[i].chk_head) begin
                chk($sformatf("tbl%0d_haddr", i), 64'(d_addr), 64'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_hdata", i), 64'(d_data), 64'(tbl[i].e_data));
                chk($sformatf("tbl%0d_hwr", i), 64'(d_wr), 64'(tbl[i].e_wr));
            end
        end

        // Writes-only mode, fill to full, then an overflowing write.
        clr = 1; tick();
        mode = 2'b01;
        for (int i = 0; i < 8; i++) do_xfer(i % 2 == 0, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 0);
        chk("m01_count", 64'(sta_count), 4);
        chk("m01_full", 64'(sta_full), 1);
        chk("m01_ovf0", 64'(sta_ovf), 0);
        do_xfer(1, 32'h300, 32'hBB, 0);
        chk("m01_ovf1", 64'(sta_ovf), 1);
        chk("m01_count5", 64'(sta_count), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m01_head%0d_addr", i), 64'(d_addr), 64'(32'h200 + 32'(8 * i)));
            chk($sformatf("m01_head%0d_data", i), 64'(d_data), 64'(32'hA0 + 32'(2 * i)));
            pop = 1; tick();
        end
        chk("m01_empty", 64'(sta_empty), 1);
        chk("m01_ovf_sticky", 64'(sta_ovf), 1);

        // Full FIFO with simultaneous push and pop, wrapping the pointers.
        clr = 1; tick();
        mode = 2'b00;
        for (int i = 0; i < 4; i++) do_xfer(1, 32'h400 + 32'(4 * i), 32'(i), 0);
        for (int k = 0; k < 7; k++) begin
            do_xfer(1, 32'h400 + 32'(4 * (4 + k)), 32'(4 + k), 1);
            chk($sformatf("pp%0d_count", k), 64'(sta_count), 4);
            chk($sformatf("pp%0d_ovf", k), 64'(sta_ovf), 0);
            chk($sformatf("pp%0d_head", k), 64'(d_addr), 64'(32'h400 + 32'(4 * (k + 1))));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap%0d_addr", i), 64'(d_addr), 64'(32'h400 + 32'(4 * (7 + i))));
            chk($sformatf("wrap%0d_data", i), 64'(d_data), 64'(7 + i));
            pop = 1; tick();
        end
        chk("wrap_empty", 64'(sta_empty), 1);

        // Three wait states then a back-to-back write.
        clr = 1; tick();
        set_bus(1, 2'b10, 1, 32'h500, 1);
        tick();
        for (int w = 0; w < 3; w++) begin
            set_bus(1, 2'b10, 1, 32'h504, 0);
            hwdata = 32'h1111_0000 + 32'(w);
            tick();
        end
        chk("ws_count0", 64'(sta_count), 0);
        set_bus(1, 2'b10, 1, 32'h504, 1); hwdata = 32'hCAFE0001;
        tick();
        chk("ws_count1", 64'(sta_count), 1);
        set_bus(0, 2'b00, 0, 32'h0, 1); hwdata = 32'hCAFE0002;
        tick();
        chk("ws_count2", 64'(sta_count), 2);
        chk("ws_h0_addr", 64'(d_addr), 32'h500);
        chk("ws_h0_data", 64'(d_data), 32'hCAFE0001);
        pop = 1; tick();
        chk("ws_h1_addr", 64'(d_addr), 32'h504);
        chk("ws_h1_data", 64'(d_data), 32'hCAFE0002);

        // Reset in a data-phase cycle discards the pending transfer.
        set_bus(1, 2'b10, 1, 32'h600, 1);
        tick();
        set_bus(0, 2'b00, 0, 32'h0, 1); hwdata = 32'h66; rst = 1;
        tick();
        rst = 0;
        tick();
        chk("rstmid_count", 64'(sta_count), 0);

        // Masked pattern match and counter saturation.
        pat_en = 1; pat_addr = 32'h100; pat_mask = 32'hFFFFFF00;
        do_xfer(1, 32'h104, 32'h1, 0);
        do_xfer(0, 32'h1FC, 32'h2, 0);
        do_xfer(1, 32'h200, 32'h3, 0);
        chk("pat_count", 64'(pc), 2);
        chk("pat_match", 64'(pm), 1);
        clr = 1; tick();
        chk("pat_clr", 64'(pc), 0);
        pat_mask = 32'h0;
        for (int i = 0; i < 20; i++) do_xfer(i[0], 32'h900 + 32'(i), 32'(i), 1);
        chk("sat_cw16", 64'(pc), 20);
        chk("sat_cw4", 64'(pc2), 15);
        chk("sat_match", 64'(pm2), 1);

        // clr in a completion cycle with three entries queued and overflow set.
        clr = 1; tick();
        for (int i = 0; i < 5; i++) do_xfer(1, 32'h700 + 32'(4 * i), 32'(i), 0);
        pop = 1; tick();
        chk("clr_pre_count", 64'(sta_count), 3);
        chk("clr_pre_ovf", 64'(sta_ovf), 1);
        set_bus(1, 2'b10, 1, 32'h7F0, 1);
        tick();
        set_bus(0, 2'b00, 0, 32'h0, 1); hwdata = 32'h77; clr = 1;
        tick();
        chk("clr_count", 64'(sta_count), 0);
        chk("clr_empty", 64'(sta_empty), 1);
        chk("clr_ovf", 64'(sta_ovf), 0);
        chk("clr_pc", 64'(pc), 0);
        chk("clr_pm", 64'(pm), 0);
        tick();
        chk("clr_after_count", 64'(sta_count), 0);

        // Randomized traffic against the reference model.
        clr = 1; tick();
        pat_addr = 32'h1000_0030; pat_mask = 32'hFFFF_FFF0;
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) mode = 2'($urandom_range(0, 3));
            snoop_en = ($urandom_range(0, 9) != 0);
            pat_en   = ($urandom_range(0, 7) != 0);
            set_bus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'h1000_0000 + 32'($urandom_range(0, 127)), $urandom_range(0, 3) != 0);
            hwdata = $urandom; hrdata = $urandom;
            pop = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 63) == 0);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
